// File: rtl/mdu_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | mdu_pkg : shared RV32M funct3 codes, states and result constants |
// | Revision: 1.0                                                    |
// +-----------------------------------------------------------------+
package mdu_pkg;

   localparam int MDU_XLEN = 32;

   localparam logic [2:0] MDU_MUL    = 3'b000;
   localparam logic [2:0] MDU_MULH   = 3'b001;
   localparam logic [2:0] MDU_MULHSU = 3'b010;
   localparam logic [2:0] MDU_MULHU  = 3'b011;
   localparam logic [2:0] MDU_DIV    = 3'b100;
   localparam logic [2:0] MDU_DIVU   = 3'b101;
   localparam logic [2:0] MDU_REM    = 3'b110;
   localparam logic [2:0] MDU_REMU   = 3'b111;

   localparam logic [31:0] INT_MIN  = 32'h8000_0000;
   localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ISSUE = 3'd1,
      WAIT  = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4
   } mdu_state_t;

endpackage
`default_nettype wire

// File: rtl/mdu_special_case.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | mdu_special_case : divide-by-zero / signed-overflow resolution   |
// | Revision: 1.0                                                    |
// +-----------------------------------------------------------------+
module mdu_special_case
   import mdu_pkg::*;
#(
   parameter int XLEN = MDU_XLEN
) (
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   output logic            is_special,
   output logic [XLEN-1:0] special_result
);

   logic w_div_zero;
   logic w_overflow;

   assign w_div_zero = (rs2 == '0);
   assign w_overflow = (rs1 == XLEN'(INT_MIN)) && (rs2 == XLEN'(ALL_ONES));

   always_comb begin
      is_special     = 1'b0;
      special_result = '0;
      case (funct3)
         MDU_DIV: begin
            if (w_div_zero) begin
               is_special     = 1'b1;
               special_result = XLEN'(ALL_ONES);
            end else if (w_overflow) begin
               is_special     = 1'b1;
               special_result = XLEN'(INT_MIN);
            end
         end
         MDU_DIVU: begin
            if (w_div_zero) begin
               is_special     = 1'b1;
               special_result = XLEN'(ALL_ONES);
            end
         end
         // Signed overflow remainder is 0, already the default result.
         MDU_REM: begin
            if (w_div_zero) begin
               is_special     = 1'b1;
               special_result = rs1;
            end else if (w_overflow) begin
               is_special     = 1'b1;
            end
         end
         MDU_REMU: begin
            if (w_div_zero) begin
               is_special     = 1'b1;
               special_result = rs1;
            end
         end
         default: begin
            is_special     = 1'b0;
            special_result = '0;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/mdu_issue_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | mdu_issue_ctrl : EX-stage issue/writeback controller for the mdu |
// | Revision: 1.0                                                    |
// +-----------------------------------------------------------------+
module mdu_issue_ctrl
   import mdu_pkg::*;
#(
   parameter int XLEN    = MDU_XLEN,
   parameter int TIMEOUT = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [2:0]      req_funct3,
   input  logic [4:0]      req_rd,
   input  logic [XLEN-1:0] req_rs1,
   input  logic [XLEN-1:0] req_rs2,
   input  logic            flush,
   output logic            mdu_valid,
   output logic [2:0]      mdu_op,
   output logic [XLEN-1:0] mdu_rs1,
   output logic [XLEN-1:0] mdu_rs2,
   input  logic [XLEN-1:0] mdu_result,
   input  logic            mdu_ready,
   output logic            wb_valid,
   output logic [4:0]      wb_rd,
   output logic [XLEN-1:0] wb_data,
   output logic            busy,
   output logic            timeout_err
);

   localparam int CW = $clog2(TIMEOUT + 1);

   mdu_state_t      r_state;
   logic [CW-1:0]   r_cnt;
   logic            r_mdu_valid;
   logic            r_wb_valid;
   logic            r_timeout;
   logic [2:0]      r_op;
   logic [XLEN-1:0] r_rs1;
   logic [XLEN-1:0] r_rs2;
   logic [4:0]      r_rd;
   logic [XLEN-1:0] r_wb_data;

   logic            w_is_special;
   logic [XLEN-1:0] w_special_result;
   logic [CW-1:0]   w_cnt_next;
   logic            w_expire;

   mdu_special_case #(.XLEN(XLEN)) u_special (
      .funct3         (req_funct3),
      .rs1            (req_rs1),
      .rs2            (req_rs2),
      .is_special     (w_is_special),
      .special_result (w_special_result)
   );

   assign w_cnt_next = r_cnt + CW'(1);
   assign w_expire   = (w_cnt_next == CW'(TIMEOUT));

   assign req_ready   = (r_state == IDLE);
   assign busy        = (r_state != IDLE);
   assign mdu_valid   = r_mdu_valid;
   assign mdu_op      = r_op;
   assign mdu_rs1     = r_rs1;
   assign mdu_rs2     = r_rs2;
   // A flush arriving during DONE must still suppress the strobe in that cycle.
   assign wb_valid    = r_wb_valid & ~flush;
   assign wb_rd       = r_rd;
   assign wb_data     = r_wb_data;
   assign timeout_err = r_timeout;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_mdu_valid <= 1'b0;
         r_wb_valid  <= 1'b0;
         r_timeout   <= 1'b0;
         r_op        <= '0;
         r_rs1       <= '0;
         r_rs2       <= '0;
         r_rd        <= '0;
         r_wb_data   <= '0;
      end else begin
         r_mdu_valid <= 1'b0;
         r_wb_valid  <= 1'b0;
         r_timeout   <= 1'b0;
         case (r_state)
            IDLE: begin
               if (req_valid && !flush) begin
                  r_op  <= req_funct3;
                  r_rs1 <= req_rs1;
                  r_rs2 <= req_rs2;
                  r_rd  <= req_rd;
                  if (w_is_special) begin
                     r_wb_data  <= w_special_result;
                     r_wb_valid <= (req_rd != 5'd0);
                     r_state    <= DONE;
                  end else begin
                     r_mdu_valid <= 1'b1;
                     r_state     <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               r_cnt   <= '0;
               r_state <= flush ? DRAIN : WAIT;
            end
            WAIT: begin
               if (mdu_ready && !flush) begin
                  r_wb_data  <= mdu_result;
                  r_wb_valid <= (r_rd != 5'd0);
                  r_state    <= DONE;
               end else if (mdu_ready) begin
                  // Flushed in the completion cycle: the response is consumed and dropped.
                  r_state <= IDLE;
               end else if (w_expire) begin
                  r_timeout <= 1'b1;
                  r_state   <= IDLE;
               end else begin
                  r_cnt <= w_cnt_next;
                  if (flush) begin
                     r_state <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (mdu_ready) begin
                  r_state <= IDLE;
               end else if (w_expire) begin
                  r_timeout <= 1'b1;
                  r_state   <= IDLE;
               end else begin
                  r_cnt <= w_cnt_next;
               end
            end
            DONE: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mdu_issue_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_mdu_issue_ctrl : scoreboard bench for mdu_issue_ctrl          |
// | Revision: 1.0                                                    |
// +-----------------------------------------------------------------+
module tb_mdu_issue_ctrl;

   localparam int XLEN    = 32;
   localparam int TIMEOUT = 8;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            req_valid = 1'b0;
   logic            req_ready;
   logic [2:0]      req_funct3 = '0;
   logic [4:0]      req_rd = '0;
   logic [XLEN-1:0] req_rs1 = '0;
   logic [XLEN-1:0] req_rs2 = '0;
   logic            flush = 1'b0;
   logic            mdu_valid;
   logic [2:0]      mdu_op;
   logic [XLEN-1:0] mdu_rs1;
   logic [XLEN-1:0] mdu_rs2;
   logic [XLEN-1:0] mdu_result = '0;
   logic            mdu_ready = 1'b0;
   logic            wb_valid;
   logic [4:0]      wb_rd;
   logic [XLEN-1:0] wb_data;
   logic            busy;
   logic            timeout_err;

   typedef struct { logic [4:0] rd; logic [31:0] data; } wb_t;
   typedef struct { logic [2:0] op; logic [31:0] rs1; logic [31:0] rs2; } iss_t;

   wb_t  exp_wb[$];
   iss_t exp_iss[$];
   int   exp_to = 0;
   int   errors = 0;
   int   checks = 0;

   mdu_issue_ctrl #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_funct3(req_funct3), .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2),
      .flush(flush), .mdu_valid(mdu_valid), .mdu_op(mdu_op), .mdu_rs1(mdu_rs1),
      .mdu_rs2(mdu_rs2), .mdu_result(mdu_result), .mdu_ready(mdu_ready),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .busy(busy),
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic unexpected(input string nm);
      checks++;
      errors++;
      $display("FAIL %s: got an unexpected strobe, expected none", nm);
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents a strobe.
   always @(negedge clk) begin
      if (rst) begin
         if (wb_valid) begin
            if (exp_wb.size() == 0) unexpected("wb_valid");
            else begin
               wb_t e;
               e = exp_wb.pop_front();
               chk("wb_rd", 32'(wb_rd), 32'(e.rd));
               chk("wb_data", wb_data, e.data);
            end
         end
         if (mdu_valid) begin
            if (exp_iss.size() == 0) unexpected("mdu_valid");
            else begin
               iss_t e;
               e = exp_iss.pop_front();
               chk("mdu_op", 32'(mdu_op), 32'(e.op));
               chk("mdu_rs1", mdu_rs1, e.rs1);
               chk("mdu_rs2", mdu_rs2, e.rs2);
            end
         end
         if (timeout_err) begin
            if (exp_to == 0) unexpected("timeout_err");
            else exp_to--;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [2:0] f3, input logic [4:0] rd,
                       input logic [31:0] a, input logic [31:0] b);
      int n = 0;
      while (!req_ready && n < 50) begin
         tick(1);
         n++;
      end
      if (!req_ready) chk("req_ready_wait", 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_funct3 = f3; req_rd = rd; req_rs1 = a; req_rs2 = b;
      tick(1);
      req_valid = 1'b0;
   endtask

   task automatic wait_issue();
      bit seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (mdu_valid) seen = 1'b1;
      end
      if (!seen) chk("mdu_valid_wait", 32'd0, 32'd1);
   endtask

   task automatic pulse_ready(input logic [31:0] data);
      mdu_ready = 1'b1; mdu_result = data;
      tick(1);
      mdu_ready = 1'b0; mdu_result = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish, expected finish");
      $fatal(1, "simulation timed out");
   end

   initial begin
      #2 rst = 1'b0;
      tick(3);
      chk("rst_mdu_valid", 32'(mdu_valid), 32'd0);
      chk("rst_wb_valid", 32'(wb_valid), 32'd0);
      chk("rst_timeout", 32'(timeout_err), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_wb_data", wb_data, 32'd0);
      rst = 1'b1;
      tick(2);

      // MUL 2*10, mdu answers 3 cycles after the issue pulse
      exp_iss.push_back('{3'b000, 32'd2, 32'd10});
      exp_wb.push_back('{5'd5, 32'd20});
      send(3'b000, 5'd5, 32'd2, 32'd10);
      wait_issue();
      tick(3);
      pulse_ready(32'd20);
      @(negedge clk);
      chk("mul_wb_timing", 32'(wb_valid), 32'd1);
      @(negedge clk);
      chk("mul_busy_after", 32'(busy), 32'd0);
      tick(1);

      // Special cases resolve locally with one-cycle latency
      exp_wb.push_back('{5'd6, 32'hFFFF_FFFF});
      send(3'b100, 5'd6, 32'd20, 32'd0);
      @(negedge clk);
      chk("div0_wb_timing", 32'(wb_valid), 32'd1);
      tick(1);
      exp_wb.push_back('{5'd7, 32'd7});
      send(3'b111, 5'd7, 32'd7, 32'd0);
      tick(2);
      exp_wb.push_back('{5'd8, 32'h8000_0000});
      send(3'b100, 5'd8, 32'h8000_0000, 32'hFFFF_FFFF);
      tick(2);
      exp_wb.push_back('{5'd9, 32'd0});
      send(3'b110, 5'd9, 32'h8000_0000, 32'hFFFF_FFFF);
      tick(2);

      // MULHU with minimum mdu latency
      exp_iss.push_back('{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF});
      exp_wb.push_back('{5'd10, 32'hFFFF_FFFE});
      send(3'b011, 5'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_issue();
      tick(1);
      pulse_ready(32'hFFFF_FFFE);
      tick(2);

      // rd=0 consumes the cycle but never strobes writeback
      exp_iss.push_back('{3'b000, 32'd3, 32'd3});
      send(3'b000, 5'd0, 32'd3, 32'd3);
      wait_issue();
      tick(2);
      pulse_ready(32'd9);
      tick(2);

      // DIVU 20/4 flushed in WAIT, response two cycles later is dropped
      exp_iss.push_back('{3'b101, 32'd20, 32'd4});
      send(3'b101, 5'd11, 32'd20, 32'd4);
      wait_issue();
      tick(1);
      flush = 1'b1;
      tick(1);
      flush = 1'b0;
      @(negedge clk);
      chk("drain_busy", 32'(busy), 32'd1);
      chk("drain_req_ready", 32'(req_ready), 32'd0);
      tick(1);
      pulse_ready(32'd5);
      @(negedge clk);
      chk("drain_exit_req_ready", 32'(req_ready), 32'd1);
      tick(1);

      // Flush during ISSUE: the pulse still goes out
      exp_iss.push_back('{3'b001, 32'd4, 32'd5});
      send(3'b001, 5'd12, 32'd4, 32'd5);
      flush = 1'b1;
      tick(1);
      flush = 1'b0;
      @(negedge clk);
      chk("issue_flush_busy", 32'(busy), 32'd1);
      tick(1);
      pulse_ready(32'd0);
      @(negedge clk);
      chk("issue_flush_idle", 32'(req_ready), 32'd1);
      tick(1);

      // Flush during DONE suppresses the strobe
      send(3'b101, 5'd13, 32'd1, 32'd0);
      flush = 1'b1;
      @(negedge clk);
      chk("done_flush_wb", 32'(wb_valid), 32'd0);
      tick(1);
      flush = 1'b0;
      @(negedge clk);
      chk("done_flush_idle", 32'(req_ready), 32'd1);
      tick(1);

      // Watchdog: no response, abort after TIMEOUT WAIT cycles
      exp_iss.push_back('{3'b000, 32'd6, 32'd7});
      exp_to++;
      send(3'b000, 5'd14, 32'd6, 32'd7);
      wait_issue();
      repeat (TIMEOUT) @(negedge clk);
      chk("to_not_yet", 32'(timeout_err), 32'd0);
      chk("to_busy", 32'(busy), 32'd1);
      @(negedge clk);
      chk("to_pulse", 32'(timeout_err), 32'd1);
      chk("to_idle", 32'(req_ready), 32'd1);
      @(negedge clk);
      chk("to_one_cycle", 32'(timeout_err), 32'd0);
      tick(1);

      // Asynchronous reset mid-WAIT, late response afterwards
      exp_iss.push_back('{3'b000, 32'd3, 32'd4});
      send(3'b000, 5'd15, 32'd3, 32'd4);
      wait_issue();
      tick(1);
      @(posedge clk);
      #3 rst = 1'b0;
      #1;
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_mdu_valid", 32'(mdu_valid), 32'd0);
      chk("arst_mdu_rs1", mdu_rs1, 32'd0);
      chk("arst_wb_rd", 32'(wb_rd), 32'd0);
      tick(2);
      rst = 1'b1;
      pulse_ready(32'd12);
      @(negedge clk);
      chk("arst_idle", 32'(req_ready), 32'd1);
      tick(2);

      chk("wb_queue_empty", 32'(exp_wb.size()), 32'd0);
      chk("iss_queue_empty", 32'(exp_iss.size()), 32'd0);
      chk("timeout_seen", 32'(exp_to), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mdu_issue_ctrl.md
Name: mdu_issue_ctrl

Overview:
- Execute-stage controller sitting directly upstream of the mdu.
- Accepts RV32M operations from the EX stage and resolves divide-by-zero and signed-overflow cases locally without launching the mdu.
- Otherwise issues a one-cycle mdu_valid pulse with operands held stable, waits for mdu_ready, and presents a single-cycle writeback to the register file.
- Also handles pipeline flush, including while an mdu operation is in flight, and a watchdog timeout.

Parameters:
- XLEN, 32, operand and result width.
- TIMEOUT, 64, maximum cycles in WAIT before abort; counter width is clog2(TIMEOUT+1).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- req_valid  input  1  EX stage presents an M-extension instruction.
- req_ready  output  1  controller can accept; equals (state==IDLE).
- req_funct3  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- req_rd  input  5  destination register.
- req_rs1  input  XLEN  operand 1 value.
- req_rs2  input  XLEN  operand 2 value.
- flush  input  1  kill the current operation; no writeback.
- mdu_valid  output  1  one-cycle issue pulse to the mdu.
- mdu_op  output  3  captured funct3.
- mdu_rs1  output  XLEN  captured operand 1.
- mdu_rs2  output  XLEN  captured operand 2.
- mdu_result  input  XLEN  mdu result; valid when mdu_ready=1.
- mdu_ready  input  1  one-cycle completion pulse from the mdu.
- wb_valid  output  1  one-cycle writeback strobe.
- wb_rd  output  5  writeback register.
- wb_data  output  XLEN  writeback value.
- busy  output  1  state!=IDLE; the hazard unit stalls on this.
- timeout_err  output  1  one-cycle pulse when the watchdog expires.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. mdu_valid=0, wb_valid=0, timeout_err=0, busy=0. mdu_op, mdu_rs1, mdu_rs2, wb_rd, wb_data and the counter all =0.
- Accept: in IDLE with req_valid=1 and flush=0, capture funct3, rd, rs1, rs2.
  - Special-case check happens at capture:
    - DIV/DIVU with rs2==0: result 0xFFFFFFFF.
    - REM/REMU with rs2==0: result rs1.
    - DIV with rs1==0x80000000 and rs2==0xFFFFFFFF: result 0x80000000.
    - REM with the same operands: result 0.
  - Special case → go to DONE. Otherwise → go to ISSUE.
- ISSUE: mdu_valid=1 for exactly one cycle; next state WAIT; counter cleared.
- WAIT: mdu_valid=0; operands stay stable; counter increments each cycle.
  - mdu_ready=1: latch mdu_result into wb_data, go to DONE.
  - Counter reaches TIMEOUT with mdu_ready=0: pulse timeout_err for one cycle, no writeback, go to IDLE.
- DONE: wb_valid=1 for one cycle with wb_rd and wb_data; next state IDLE.
  - If rd==0, wb_valid stays 0 and the cycle is still consumed.
- Latency from accept edge to wb_valid:
  - Special case: 1 cycle.
  - mdu path: mdu latency + 2 cycles (ISSUE, then DONE).
- mdu_ready handling: if it arrives in the same cycle as the ISSUE pulse, it is ignored; the mdu must respond no earlier than the cycle after mdu_valid. mdu_ready outside WAIT/DRAIN is ignored.
- Flush:
  - IDLE: the request is not accepted.
  - ISSUE: go to DRAIN; mdu_valid is still asserted that cycle because the issue is already committed.
  - WAIT: go to DRAIN.
  - DONE: wb_valid is forced to 0 that cycle; go to IDLE.
- DRAIN: wait for mdu_ready (or timeout), discard the result, go to IDLE. The watchdog stays active.
- Flush has priority over mdu_ready in the same cycle: the result is discarded.
- req_ready is a combinational decode of state only; there is no back-to-back accept from DONE.

Decomposition:
- Shared package mdu_pkg: funct3 constants (MDU_MUL..MDU_REMU), state encoding (IDLE, ISSUE, WAIT, DRAIN, DONE), and the constants INT_MIN=0x80000000 and ALL_ONES.
- Natural sub-module: mdu_special_case. Purely combinational; inputs funct3, rs1, rs2; outputs is_special and special_result. It is reused by the formal checker.

Test Plan:
- MUL rs1=2, rs2=10; mdu returns 20 three cycles after mdu_valid → one mdu_valid pulse with mdu_op=000, mdu_rs1=2, mdu_rs2=10; wb_valid one cycle later with wb_data=20, rd preserved; busy=0 afterwards.
- DIV rs1=20, rs2=0 → no mdu_valid; wb_valid on the next cycle with wb_data=0xFFFFFFFF. REMU 7%0 → wb_data=7.
- DIV rs1=0x80000000, rs2=0xFFFFFFFF → no mdu_valid; wb_data=0x80000000. REM with the same operands → wb_data=0.
- DIVU 20/4 with flush asserted in WAIT; mdu_ready 2 cycles later → state goes to DRAIN; no wb_valid; req_ready returns 1 the cycle after mdu_ready.
- mdu never asserts mdu_ready, TIMEOUT=8 → timeout_err pulses once 8 cycles into WAIT; no wb_valid; controller returns to IDLE.
- rst deasserted (driven low) asynchronously mid-WAIT → all outputs 0 immediately; a late mdu_ready after reset release produces no wb_valid.
